// File: rtl/vga_pkg.sv
// Shared widths, screen geometry, FSM encoding and rectangle type for the VGA fill path.
`timescale 1ns/1ps
package vga_pkg;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int COLOR_W      = 24;
    localparam int CNT_W        = 19;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLIP,
        ST_WAIT_VBL,
        ST_FILL,
        ST_DONE
    } fill_state_t;

    typedef struct packed {
        logic [X_W-1:0] xmin;
        logic [X_W-1:0] xmax;
        logic [Y_W-1:0] ymin;
        logic [Y_W-1:0] ymax;
    } rect_t;
endpackage

// File: rtl/rect_raster_counter.sv
// Raster-order cursor over a loaded rectangle; flags when the cursor sits on the last pixel.
`timescale 1ns/1ps
module rect_raster_counter
    import vga_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic           step_i,
    input  rect_t          rect_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);
    logic [X_W-1:0] x_q, x_d, xmin_q, xmax_q;
    logic [Y_W-1:0] y_q, y_d, ymax_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = rect_i.xmin;
            y_d = rect_i.ymin;
        end else if (step_i) begin
            if (x_q == xmax_q) begin
                x_d = xmin_q;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_q    <= '0;
            y_q    <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (load_i) begin
                xmin_q <= rect_i.xmin;
                xmax_q <= rect_i.xmax;
                ymax_q <= rect_i.ymax;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == xmax_q) && (y_q == ymax_q);
endmodule

// File: rtl/vga_rect_fill_sequencer.sv
// Turns one rectangle-fill command into clipped, raster-ordered single-pixel framebuffer writes.
`timescale 1ns/1ps
module vga_rect_fill_sequencer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE_DEF,
    parameter int SYNC_VBL = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               abort,
    input  logic               vblank_start,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pix_count
);
    localparam logic [X_W:0]   H_LIM  = (X_W+1)'(H_ACTIVE);
    localparam logic [Y_W:0]   V_LIM  = (Y_W+1)'(V_ACTIVE);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    fill_state_t          state_q, state_d;
    rect_t                rect_q, clip_rect;
    logic [COLOR_W-1:0]   color_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 empty, accept, hs, load, last;

    // Clip is evaluated combinationally from the sorted corners while in CLIP.
    always_comb begin
        clip_rect      = rect_q;
        clip_rect.xmax = (rect_q.xmax > X_LAST) ? X_LAST : rect_q.xmax;
        clip_rect.ymax = (rect_q.ymax > Y_LAST) ? Y_LAST : rect_q.ymax;
    end

    assign empty  = ({1'b0, rect_q.xmin} >= H_LIM) || ({1'b0, rect_q.ymin} >= V_LIM);
    assign accept = cmd_valid && cmd_ready;
    assign hs     = pix_valid && pix_ready;
    assign load   = (state_q == ST_CLIP) && !empty && !abort;

    rect_raster_counter u_cursor (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .load_i (load),
        .step_i (hs),
        .rect_i (clip_rect),
        .x_o    (pix_x),
        .y_o    (pix_y),
        .last_o (last)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (cmd_valid) state_d = ST_CLIP;
            ST_CLIP:     if (abort || empty)     state_d = ST_IDLE;
                         else if (SYNC_VBL != 0) state_d = ST_WAIT_VBL;
                         else                    state_d = ST_FILL;
            ST_WAIT_VBL: if (abort)             state_d = ST_IDLE;
                         else if (vblank_start) state_d = ST_FILL;
            ST_FILL:     if (abort)             state_d = ST_IDLE;
                         else if (hs && last)   state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        pix_valid = (state_q == ST_FILL);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept)                cnt_d = '0;
        else if (hs && ~&cnt_q)    cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rect_q  <= '0;
            color_q <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                rect_q.xmin <= (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
                rect_q.xmax <= (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
                rect_q.ymin <= (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
                rect_q.ymax <= (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
                color_q     <= cmd_color;
            end
        end
    end

    assign pix_color = color_q;
    assign pix_count = cnt_q;
endmodule

// File: tb/tb_vga_rect_fill_sequencer.sv
// Bench: table of fill commands plus random commands against a queue-based pixel model, and
// hand sequences for abort, reset mid-fill and vblank-synchronised start.
`timescale 1ns/1ps
module tb_vga_rect_fill_sequencer;
    import vga_pkg::*;

    typedef struct { int x0; int y0; int x1; int y1; int n; bit dn; bit rnd; } vec_t;
    typedef struct { int x; int y; } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, cmd_valid, cmd_valid1, abort, vblank0, vblank1, pix_ready;
    logic [X_W-1:0]     cmd_x0, cmd_x1;
    logic [Y_W-1:0]     cmd_y0, cmd_y1;
    logic [COLOR_W-1:0] cmd_color;
    logic               cmd_ready, pix_valid, busy, done;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic [CNT_W-1:0]   pix_count;
    logic               cmd_ready1, pix_valid1, busy1, done1;
    logic [X_W-1:0]     pix_x1;
    logic [Y_W-1:0]     pix_y1;
    logic [COLOR_W-1:0] pix_color1;
    logic [CNT_W-1:0]   pix_count1;

    vga_rect_fill_sequencer #(.SYNC_VBL(0)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
        .abort(abort), .vblank_start(vblank0), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .busy(busy), .done(done),
        .pix_count(pix_count));

    vga_rect_fill_sequencer #(.SYNC_VBL(1)) dut_vbl (
        .clk_clk(clk), .reset_reset_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
        .abort(abort), .vblank_start(vblank1), .pix_valid(pix_valid1), .pix_ready(pix_ready),
        .pix_x(pix_x1), .pix_y(pix_y1), .pix_color(pix_color1), .busy(busy1), .done(done1),
        .pix_count(pix_count1));

    int   nvec = 0;
    int   nerr = 0;
    pix_t exp_q[$];
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected write list straight from the rules: sort corners, clip, raster-scan.
    function automatic void model(input int x0, input int y0, input int x1, input int y1);
        int xl, xh, yl, yh;
        pix_t p;
        xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
        exp_q.delete();
        if (xl >= 640 || yl >= 480) return;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                p.x = x; p.y = y;
                exp_q.push_back(p);
            end
    endfunction

    task automatic set_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [COLOR_W-1:0] col);
        cmd_x0 = X_W'(x0); cmd_x1 = X_W'(x1);
        cmd_y0 = Y_W'(y0); cmd_y1 = Y_W'(y1);
        cmd_color = col;
    endtask

    // Starts right after a negedge with the DUT idle; ends one cycle after completion.
    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                           input int n_in, input bit dn, input bit rnd);
        int n, acc, first, ndone;
        bit fin, stall;
        logic [X_W-1:0] sx;
        logic [Y_W-1:0] sy;
        logic [COLOR_W-1:0] col;
        pix_t e;
        model(x0, y0, x1, y1);
        n = (n_in < 0) ? exp_q.size() : n_in;
        col = COLOR_W'($urandom);
        chk("cmd_ready", cmd_ready, 1);
        set_cmd(x0, y0, x1, y1, col);
        cmd_valid = 1'b1; pix_ready = 1'b0;
        acc = 0; first = -1; ndone = 0; fin = 0; stall = 0; sx = '0; sy = '0;
        for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_x", pix_x, sx);
                chk("stall_y", pix_y, sy);
                chk("stall_color", pix_color, col);
            end
            if (pix_valid && first < 0) first = cyc;
            if (done) begin
                ndone++; fin = 1; pix_ready = 1'b0;
            end else if (!busy) begin
                fin = 1; pix_ready = 1'b0;
            end else begin
                pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                stall = pix_valid && !pix_ready;
                sx = pix_x; sy = pix_y;
                if (pix_valid && pix_ready) begin
                    acc++;
                    if (exp_q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL extra_pix: got write at (%0d,%0d), expected none", pix_x, pix_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_x", pix_x, e.x);
                        chk("pix_y", pix_y, e.y);
                        chk("pix_color", pix_color, col);
                    end
                end
            end
        end
        chk("timeout", fin, 1);
        chk("n_writes", acc, n);
        chk("done_seen", ndone, dn);
        chk("pix_count", pix_count, n);
        if (n > 0) chk("latency", first, 2);
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic issue(input int x0, input int y0, input int x1, input int y1);
        set_cmd(x0, y0, x1, y1, 24'h123456);
        cmd_valid = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int acc, x0, y0, x1, y1, t;
        bit hit;
        tbl[0] = '{2, 3, 4, 4, 6, 1, 0};
        tbl[1] = '{4, 4, 2, 3, 6, 1, 0};
        tbl[2] = '{630, 470, 700, 500, 100, 1, 0};
        tbl[3] = '{650, 10, 700, 20, 0, 0, 0};
        tbl[4] = '{5, 5, 5, 5, 1, 1, 0};
        tbl[5] = '{0, 479, 3, 479, 4, 1, 1};
        tbl[6] = '{639, 0, 639, 2, 3, 1, 1};
        tbl[7] = '{10, 480, 20, 500, 0, 0, 0};
        tbl[8] = '{1, 1, 3, 3, 9, 1, 1};
        tbl[9] = '{9, 9, 0, 0, 100, 1, 1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid1 = 1'b0; abort = 1'b0;
        vblank0 = 1'b0; vblank1 = 1'b0; pix_ready = 1'b0;
        set_cmd(0, 0, 0, 0, '0);
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_pix_color", pix_color, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix_count", pix_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_cmd(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].n, tbl[i].dn, tbl[i].rnd);

        for (int r = 0; r < 20; r++) begin
            x0 = $urandom_range(0, 660); x1 = x0 + $urandom_range(0, 7);
            y0 = $urandom_range(0, 500); y1 = y0 + $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin t = x0; x0 = x1; x1 = t; end
            if ($urandom_range(0, 1) == 1) begin t = y0; y0 = y1; y1 = t; end
            model(x0, y0, x1, y1);
            run_cmd(x0, y0, x1, y1, -1, exp_q.size() > 0, 1);
        end

        // Abort coinciding with the 5th accepted pixel: that pixel counts, then idle.
        issue(1, 1, 3, 3);
        acc = 0; hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (pix_valid && acc == 4) begin abort = 1'b1; hit = 1; end
            else begin if (pix_valid) acc++; @(negedge clk); end
        end
        chk("abort_reached", hit, 1);
        @(negedge clk);
        abort = 1'b0; pix_ready = 1'b0;
        chk("abort_pix_valid", pix_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_pix_count", pix_count, 5);
        @(negedge clk);
        chk("abort_no_late_done", done, 0);
        chk("abort_count_kept", pix_count, 5);

        // Reset in the middle of a fill.
        issue(1, 1, 3, 3);
        acc = 0; hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (pix_valid && acc == 5) begin rst_n = 1'b0; pix_ready = 1'b0; hit = 1; end
            else begin if (pix_valid) acc++; @(negedge clk); end
        end
        chk("reset_reached", hit, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_pix_valid", pix_valid, 0);
        chk("mrst_done", done, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_pix_count", pix_count, 0);
        chk("mrst_pix_x", pix_x, 0);
        @(negedge clk);
        chk("mrst_no_done", done, 0);
        run_cmd(2, 3, 4, 4, 6, 1, 0);

        // Vblank-synchronised instance holds off until the pulse.
        chk("vbl_cmd_ready", cmd_ready1, 1);
        set_cmd(4, 4, 2, 2, 24'hA5C3E1);
        cmd_valid1 = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("vbl_hold", pix_valid1, 0);
            @(negedge clk);
        end
        chk("vbl_busy", busy1, 1);
        vblank1 = 1'b1;
        @(negedge clk);
        vblank1 = 1'b0;
        chk("vbl_first_valid", pix_valid1, 1);
        chk("vbl_first_x", pix_x1, 2);
        chk("vbl_first_y", pix_y1, 2);
        chk("vbl_color", pix_color1, 24'hA5C3E1);
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (done1) hit = 1;
        end
        chk("vbl_done", hit, 1);
        chk("vbl_count", pix_count1, 9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
